// File: rtl/event_timestamper_mc.sv
// Multi-channel event timestamper: pairs start/end events per ID, measures the
// cycle delta, optionally expires stale IDs, and queues result records in a FIFO.
module event_timestamper_mc #(
    parameter int              ID_W       = 4,
    parameter int              TS_W       = 64,
    parameter int              FIFO_DEPTH = 8,
    parameter logic [TS_W-1:0] TIMEOUT    = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [ID_W-1:0] start_id,
    input  logic            end_valid,
    output logic            end_ready,
    input  logic [ID_W-1:0] end_id,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ID_W-1:0] out_id,
    output logic [TS_W-1:0] out_start_ts,
    output logic [TS_W-1:0] out_end_ts,
    output logic [TS_W-1:0] out_ts,
    output logic [1:0]      out_status,
    output logic [ID_W:0]   active_cnt
);

    localparam int             DEPTH      = 2 ** ID_W;
    localparam int             AW         = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    FULL_CNT   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [1:0]     ST_OK      = 2'b00;
    localparam logic [1:0]     ST_TIMEOUT = 2'b01;
    localparam logic [1:0]     ST_ORPHAN  = 2'b10;

    logic [TS_W-1:0] r_cnt;
    logic [DEPTH-1:0] r_active;
    logic [TS_W-1:0] r_startTs [DEPTH];
    logic [ID_W-1:0] r_scanIdx;
    logic [ID_W:0]   r_activeCnt;

    logic [ID_W-1:0] r_fifoId     [FIFO_DEPTH];
    logic [TS_W-1:0] r_fifoStart  [FIFO_DEPTH];
    logic [TS_W-1:0] r_fifoEnd    [FIFO_DEPTH];
    logic [TS_W-1:0] r_fifoDelta  [FIFO_DEPTH];
    logic [1:0]      r_fifoStatus [FIFO_DEPTH];
    logic [AW-1:0]   r_wrPtr;
    logic [AW-1:0]   r_rdPtr;
    logic [AW:0]     r_count;

    logic            w_full;
    logic            w_startFire;
    logic            w_endFire;
    logic            w_endActive;
    logic            w_endClear;
    logic            w_pop;
    logic [TS_W-1:0] w_scanAge;
    logic            w_expireCand;
    logic            w_expire;
    logic            w_scanAdvance;

    logic            w_push;
    logic [ID_W-1:0] w_pushId;
    logic [TS_W-1:0] w_pushStart;
    logic [TS_W-1:0] w_pushEnd;
    logic [TS_W-1:0] w_pushDelta;
    logic [1:0]      w_pushStatus;

    // A start on the same ID as a concurrent end is held off so the end closes the old interval first.
    assign w_full      = (r_count == FULL_CNT);
    assign start_ready = !rst && !r_active[start_id] && !(end_valid && (end_id == start_id));
    assign end_ready   = !rst && !w_full;
    assign w_startFire = start_valid && start_ready;
    assign w_endFire   = end_valid && end_ready;
    assign w_endActive = r_active[end_id];
    assign w_endClear  = w_endFire && w_endActive;
    assign w_pop       = (r_count != '0) && out_ready;

    // A blocked expiry keeps the scanner parked on the entry until it can be pushed.
    assign w_scanAge     = r_cnt - r_startTs[r_scanIdx];
    assign w_expireCand  = (TIMEOUT != '0) && r_active[r_scanIdx] && (w_scanAge >= TIMEOUT);
    assign w_expire      = w_expireCand && !w_endFire && !w_full &&
                           !(end_valid && (end_id == r_scanIdx));
    assign w_scanAdvance = (TIMEOUT != '0) && (!w_expireCand || w_expire);

    always_comb begin
        w_push       = 1'b0;
        w_pushId     = '0;
        w_pushStart  = '0;
        w_pushEnd    = '0;
        w_pushDelta  = '0;
        w_pushStatus = ST_OK;
        if (w_endFire) begin
            w_push    = 1'b1;
            w_pushId  = end_id;
            w_pushEnd = r_cnt;
            if (w_endActive) begin
                w_pushStart  = r_startTs[end_id];
                w_pushDelta  = r_cnt - r_startTs[end_id];
                w_pushStatus = ST_OK;
            end else begin
                w_pushStatus = ST_ORPHAN;
            end
        end else if (w_expire) begin
            w_push       = 1'b1;
            w_pushId     = r_scanIdx;
            w_pushStart  = r_startTs[r_scanIdx];
            w_pushEnd    = r_cnt;
            w_pushDelta  = w_scanAge;
            w_pushStatus = ST_TIMEOUT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_active    <= '0;
            r_scanIdx   <= '0;
            r_activeCnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            if (w_endClear) r_active[end_id] <= 1'b0;
            if (w_expire) r_active[r_scanIdx] <= 1'b0;
            if (w_startFire) r_active[start_id] <= 1'b1;
            if (w_scanAdvance) r_scanIdx <= r_scanIdx + 1'b1;
            r_activeCnt <= r_activeCnt + (ID_W + 1)'(w_startFire)
                           - (ID_W + 1)'(w_endClear) - (ID_W + 1)'(w_expire);
        end
    end

    always_ff @(posedge clk) begin
        if (w_startFire) r_startTs[start_id] <= r_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop) r_rdPtr <= r_rdPtr + 1'b1;
            r_count <= r_count + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifoId[r_wrPtr]     <= w_pushId;
            r_fifoStart[r_wrPtr]  <= w_pushStart;
            r_fifoEnd[r_wrPtr]    <= w_pushEnd;
            r_fifoDelta[r_wrPtr]  <= w_pushDelta;
            r_fifoStatus[r_wrPtr] <= w_pushStatus;
        end
    end

    // Data is forced to zero while empty so reset leaves the record outputs clean.
    assign out_valid    = (r_count != '0);
    assign out_id       = out_valid ? r_fifoId[r_rdPtr]     : '0;
    assign out_start_ts = out_valid ? r_fifoStart[r_rdPtr]  : '0;
    assign out_end_ts   = out_valid ? r_fifoEnd[r_rdPtr]    : '0;
    assign out_ts       = out_valid ? r_fifoDelta[r_rdPtr]  : '0;
    assign out_status   = out_valid ? r_fifoStatus[r_rdPtr] : 2'b00;
    assign active_cnt   = r_activeCnt;

endmodule

// File: tb/tb_event_timestamper_mc.sv
// Self-checking bench for event_timestamper_mc: directed scenarios plus randomized
// traffic compared against a record-level reference model of the timestamper.
module tb_event_timestamper_mc;

    localparam int NID     = 8;
    localparam int TSMOD   = 256;
    localparam int TMO     = 20;
    localparam int FDEPTH  = 8;

    typedef struct {
        int id;
        int st;
        int en;
        int ts;
        int status;
    } rec_t;

    logic       clk;
    logic       rst;
    logic       start_valid;
    logic       start_ready;
    logic [2:0] start_id;
    logic       end_valid;
    logic       end_ready;
    logic [2:0] end_id;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_id;
    logic [7:0] out_start_ts;
    logic [7:0] out_end_ts;
    logic [7:0] out_ts;
    logic [1:0] out_status;
    logic [3:0] active_cnt;

    int   testsRun;
    int   testsFailed;

    bit   mActive [NID];
    int   mStart  [NID];
    int   mCnt;
    int   mScan;
    rec_t mQ [$];

    event_timestamper_mc #(
        .ID_W      (3),
        .TS_W      (8),
        .FIFO_DEPTH(FDEPTH),
        .TIMEOUT   (8'd20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .start_id    (start_id),
        .end_valid   (end_valid),
        .end_ready   (end_ready),
        .end_id      (end_id),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_id      (out_id),
        .out_start_ts(out_start_ts),
        .out_end_ts  (out_end_ts),
        .out_ts      (out_ts),
        .out_status  (out_status),
        .active_cnt  (active_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic int countActive();
        int n = 0;
        for (int i = 0; i < NID; i++) n += mActive[i] ? 1 : 0;
        return n;
    endfunction

    function automatic void modelClear();
        for (int i = 0; i < NID; i++) begin
            mActive[i] = 1'b0;
            mStart[i]  = 0;
        end
        mQ.delete();
        mCnt  = 0;
        mScan = 0;
    endfunction

    // Called just after a rising edge; drives one cycle, checks DUT against the model, then advances the model.
    task automatic applyStimulus(input bit sv, input int sid, input bit ev, input int eid, input bit ordy);
        bit   expSr, expEr, endFire, startFire, full, cand, expire;
        int   age;
        rec_t r;
        start_valid = sv;
        start_id    = sid[2:0];
        end_valid   = ev;
        end_id      = eid[2:0];
        out_ready   = ordy;
        #1;
        expSr = !mActive[sid] && !(ev && eid == sid);
        expEr = mQ.size() < FDEPTH;
        checkOutput("start_ready", start_ready, expSr);
        checkOutput("end_ready", end_ready, expEr);
        checkOutput("out_valid", out_valid, mQ.size() != 0);
        if (mQ.size() != 0) begin
            checkOutput("out_id", out_id, mQ[0].id);
            checkOutput("out_start_ts", out_start_ts, mQ[0].st);
            checkOutput("out_end_ts", out_end_ts, mQ[0].en);
            checkOutput("out_ts", out_ts, mQ[0].ts);
            checkOutput("out_status", out_status, mQ[0].status);
        end
        checkOutput("active_cnt", active_cnt, countActive());
        @(posedge clk);
        endFire   = ev && expEr;
        startFire = sv && expSr;
        full      = mQ.size() >= FDEPTH;
        age       = (mCnt - mStart[mScan] + TSMOD) % TSMOD;
        cand      = mActive[mScan] && age >= TMO;
        expire    = cand && !endFire && !full && !(ev && eid == mScan);
        if (ordy && mQ.size() != 0) void'(mQ.pop_front());
        if (endFire) begin
            r.id = eid;
            r.en = mCnt;
            if (mActive[eid]) begin
                r.st         = mStart[eid];
                r.ts         = (mCnt - mStart[eid] + TSMOD) % TSMOD;
                r.status     = 0;
                mActive[eid] = 1'b0;
            end else begin
                r.st     = 0;
                r.ts     = 0;
                r.status = 2;
            end
            mQ.push_back(r);
        end else if (expire) begin
            r.id   = mScan;
            r.st   = mStart[mScan];
            r.en   = mCnt;
            r.ts   = age;
            r.status = 1;
            mQ.push_back(r);
            mActive[mScan] = 1'b0;
        end
        if (startFire) begin
            mActive[sid] = 1'b1;
            mStart[sid]  = mCnt;
        end
        if (!cand || expire) mScan = (mScan + 1) % NID;
        mCnt = (mCnt + 1) % TSMOD;
        #1;
    endtask

    task automatic doReset();
        rst         = 1'b1;
        start_valid = 1'b1;
        start_id    = 3'd0;
        end_valid   = 1'b1;
        end_id      = 3'd1;
        out_ready   = 1'b0;
        #1;
        checkOutput("rst_start_ready", start_ready, 0);
        checkOutput("rst_end_ready", end_ready, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        start_valid = 1'b0;
        end_valid   = 1'b0;
        modelClear();
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_active_cnt", active_cnt, 0);
        checkOutput("rst_out_id", out_id, 0);
        checkOutput("rst_out_start", out_start_ts, 0);
        checkOutput("rst_out_end", out_end_ts, 0);
        checkOutput("rst_out_ts", out_ts, 0);
        checkOutput("rst_out_status", out_status, 0);
    endtask

    task automatic idleUntil(input int target, input bit ordy);
        int guard = 0;
        while (mCnt != target && guard < 2 * TSMOD) begin
            applyStimulus(0, 0, 0, 0, ordy);
            guard++;
        end
    endtask

    initial begin
        int startCnt, extraSeen, loops;
        int ids [9];
        testsRun    = 0;
        testsFailed = 0;
        rst         = 1'b1;
        start_valid = 1'b0;
        start_id    = '0;
        end_valid   = 1'b0;
        end_id      = '0;
        out_ready   = 1'b0;
        modelClear();
        @(posedge clk);
        #1;
        doReset();

        // Orphan end: id 5 at cnt 7
        idleUntil(7, 1);
        applyStimulus(0, 0, 1, 5, 0);
        checkOutput("orphan_valid", out_valid, 1);
        checkOutput("orphan_id", out_id, 5);
        checkOutput("orphan_start", out_start_ts, 0);
        checkOutput("orphan_end", out_end_ts, 7);
        checkOutput("orphan_ts", out_ts, 0);
        checkOutput("orphan_status", out_status, 2);
        checkOutput("orphan_active_cnt", active_cnt, 0);
        applyStimulus(0, 0, 0, 0, 1);

        // Basic interval: start id 3 at cnt 10, end at cnt 25
        idleUntil(10, 1);
        applyStimulus(1, 3, 0, 0, 1);
        idleUntil(25, 1);
        applyStimulus(0, 0, 1, 3, 1);
        checkOutput("basic_valid", out_valid, 1);
        checkOutput("basic_id", out_id, 3);
        checkOutput("basic_start", out_start_ts, 10);
        checkOutput("basic_end", out_end_ts, 25);
        checkOutput("basic_ts", out_ts, 15);
        checkOutput("basic_status", out_status, 0);
        applyStimulus(0, 0, 0, 0, 1);

        // Duplicate start back-pressure and same-cycle start/end on one ID
        applyStimulus(1, 2, 0, 0, 1);
        start_valid = 1'b1;
        start_id    = 3'd2;
        #1;
        checkOutput("dup_start_ready", start_ready, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 2, 0, 0, 1);
        checkOutput("dup_active_cnt", active_cnt, 1);
        applyStimulus(1, 2, 1, 2, 1);
        checkOutput("same_id_active_cnt", active_cnt, 0);
        checkOutput("same_id_status", out_status, 0);
        checkOutput("same_id_rec", out_id, 2);
        applyStimulus(1, 2, 0, 0, 1);
        checkOutput("restart_active_cnt", active_cnt, 1);
        applyStimulus(0, 0, 1, 2, 1);
        applyStimulus(0, 0, 0, 0, 1);

        // Timeout: start id 1, no end, records held back until seen
        startCnt = mCnt;
        applyStimulus(1, 1, 0, 0, 0);
        loops = 0;
        while (!out_valid && loops < 60) begin
            applyStimulus(0, 0, 0, 0, 0);
            loops++;
        end
        checkOutput("timeout_seen", out_valid, 1);
        checkOutput("timeout_id", out_id, 1);
        checkOutput("timeout_status", out_status, 1);
        checkOutput("timeout_start", out_start_ts, startCnt);
        checkOutput("timeout_range", (out_ts >= 8'd20 && out_ts <= 8'd28), 1);
        applyStimulus(0, 0, 0, 0, 1);
        extraSeen = 0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid) extraSeen++;
            applyStimulus(0, 0, 0, 0, 1);
        end
        checkOutput("timeout_once", extraSeen, 0);
        applyStimulus(0, 0, 1, 1, 0);
        checkOutput("late_end_status", out_status, 2);
        checkOutput("late_end_id", out_id, 1);
        applyStimulus(0, 0, 0, 0, 1);

        // Counter wrap: start at 250, end at 4
        idleUntil(250, 1);
        applyStimulus(1, 4, 0, 0, 1);
        idleUntil(4, 1);
        applyStimulus(0, 0, 1, 4, 1);
        checkOutput("wrap_start", out_start_ts, 250);
        checkOutput("wrap_end", out_end_ts, 4);
        checkOutput("wrap_ts", out_ts, 10);
        checkOutput("wrap_status", out_status, 0);
        applyStimulus(0, 0, 0, 0, 1);

        // FIFO full: nine ends with out_ready low
        for (int i = 0; i < 9; i++) ids[i] = $urandom_range(0, NID - 1);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, ids[i], 0);
        end_valid = 1'b1;
        end_id    = ids[8][2:0];
        #1;
        checkOutput("full_end_ready", end_ready, 0);
        checkOutput("full_order_0", out_id, ids[0]);
        applyStimulus(0, 0, 1, ids[8], 1);
        applyStimulus(0, 0, 1, ids[8], 0);
        for (int k = 1; k < 9; k++) begin
            checkOutput("full_order", out_id, ids[k]);
            applyStimulus(0, 0, 0, 0, 1);
        end
        checkOutput("full_drained", out_valid, 0);

        // Randomized traffic with occasional mid-operation reset
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                doReset();
            end else begin
                applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, NID - 1),
                              $urandom_range(0, 9) < 4, $urandom_range(0, NID - 1),
                              $urandom_range(0, 9) < 6);
            end
        end
        doReset();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/event_timestamper_mc.md
EVENT_TIMESTAMPER_MC -- requirements
Module: event_timestamper_mc

Interface
REQ-001 SHALL have parameter ID_W, default 4: event ID width; DEPTH = 2**ID_W scoreboard entries.
REQ-002 SHALL have parameter TS_W, default 64: timestamp counter width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, power of two >= 2: output record FIFO depth.
REQ-004 SHALL have parameter TIMEOUT, default 0: per-ID timeout in cycles (TS_W wide); 0 disables timeout.
REQ-005 SHALL have port clk  in  1  clock; all logic on posedge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have ports start_valid in 1, start_ready out 1, start_id in ID_W: start-event handshake.
REQ-008 SHALL have ports end_valid in 1, end_ready out 1, end_id in ID_W: end-event handshake.
REQ-009 SHALL have ports out_valid out 1, out_ready in 1: output record handshake.
REQ-010 SHALL have ports out_id out ID_W, out_start_ts/out_end_ts/out_ts out TS_W each: record ID, start, end, delta.
REQ-011 SHALL have port out_status out 2: 00 OK, 01 TIMEOUT, 10 ORPHAN_END, 11 reserved.
REQ-012 SHALL have port active_cnt out ID_W+1: number of IDs currently in flight.

Function
REQ-013 Free-running counter cnt: 0 after reset, +1 every cycle, wraps modulo 2**TS_W.
REQ-014 Handshake fires when valid && ready on a clock edge; valid with ready low holds off without loss.
REQ-015 start_ready = !active[start_id] && !(end_valid && end_id == start_id); duplicate start back-pressures.
REQ-016 Start fire: active[start_id] <= 1, start_ts[start_id] <= cnt value of the fire cycle.
REQ-017 end_ready = !fifo_full; no same-cycle pop bypass.
REQ-018 End fire with active[end_id]=1: push {end_id, start_ts, cnt, cnt-start_ts, OK}; clear active[end_id].
REQ-019 End fire with active[end_id]=0: push {end_id, 0, cnt, 0, ORPHAN_END}; scoreboard unchanged.
REQ-020 Delta = (end_ts - start_ts) modulo 2**TS_W; correct across one counter wrap.
REQ-021 Same-cycle start and end, same ID: end processed, start stalled (REQ-015); start fires next cycle at earliest.
REQ-022 Same-cycle start and end, different IDs: both fire.
REQ-023 Timeout scanner (TIMEOUT != 0): pointer scan_idx visits one entry per cycle, increments modulo DEPTH.
REQ-024 Scanned entry expires when active && (cnt - start_ts) >= TIMEOUT, delta modulo 2**TS_W.
REQ-025 Expiry push: {scan_idx, start_ts, cnt, delta, TIMEOUT}; clear active[scan_idx].
REQ-026 Expiry allowed only if no end fire that cycle, FIFO not full, and end_id != scan_idx while end_valid; else scan_idx holds.
REQ-027 Scanner reads registered scoreboard state; a start firing this cycle is not seen until next visit.
REQ-028 FIFO accepts at most one push per cycle; end fire has priority over expiry.
REQ-029 Latency: record pushed at edge N shows at outputs from cycle N+1 if FIFO was empty.
REQ-030 out_* held stable while out_valid && !out_ready; pop on out_valid && out_ready; push and pop in same cycle allowed.
REQ-031 active_cnt: +1 on start fire, -1 on OK clear or expiry, net 0 when both same cycle; never exceeds DEPTH.
REQ-032 TIMEOUT = 0: scanner inert, no TIMEOUT records ever produced.

Reset
REQ-033 Reset: cnt=0, all active=0, scan_idx=0, FIFO empty, out_valid=0, active_cnt=0, out_* data=0.
REQ-034 Reset mid-operation discards all in-flight IDs and queued records; no record emitted for them.
REQ-035 During reset start_ready=0, end_ready=0.

Verification
REQ-036 Start id=3 at cnt=10, end id=3 at cnt=25 -> one record id=3, start 10, end 25, ts 15, status OK, out_valid at cnt=26.
REQ-037 End id=5 with no prior start at cnt=7 -> record id=5, start 0, end 7, ts 0, status ORPHAN_END; active_cnt stays 0.
REQ-038 Start id=2 then start id=2 again before end -> second start_ready=0 until end id=2 fires; active_cnt peaks at 1.
REQ-039 TIMEOUT=20, start id=1 at cnt=0, no end -> exactly one TIMEOUT record id=1, ts >= 20 and <= 20+DEPTH; later end id=1 gives ORPHAN_END.
REQ-040 TS_W=8, start at cnt=250, end at cnt=4 after wrap -> ts 10, status OK.
REQ-041 out_ready=0, FIFO_DEPTH=8, 9 end events -> 8 accepted, end_ready=0 on 9th; after one pop 9th accepted; records in order, none lost.
